id_ex_stage: RTL and testbench

//  ID/EX pipeline register with load-use hazard detection for the 5-stage MIPS core.

---
 rtl/mips_pkg.sv | 46 ++++
 rtl/load_use_detect.sv | 30 +++
 rtl/id_ex_stage.sv | 137 +++++++++++++
 tb/tb_id_ex_stage.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types for the 5-stage MIPS core: control bundle, ID/EX
// register image, hazard FSM states and ALU op codes.
package mips_pkg;

  localparam int CTRL_W = 10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [3:0] ALU_OP_ADD = 4'd0;
  localparam logic [3:0] ALU_OP_SUB = 4'd1;
  localparam logic [3:0] ALU_OP_AND = 4'd2;
  localparam logic [3:0] ALU_OP_OR  = 4'd3;
  localparam logic [3:0] ALU_OP_XOR = 4'd4;
  localparam logic [3:0] ALU_OP_NOR = 4'd5;
  localparam logic [3:0] ALU_OP_SLT = 4'd6;
  localparam logic [3:0] ALU_OP_SLL = 4'd7;
  localparam logic [3:0] ALU_OP_SRL = 4'd8;
  localparam logic [3:0] ALU_OP_LUI = 4'd9;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [3:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic        valid;
    ctrl_t       ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] imm32;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
  } id_ex_t;

  typedef enum logic {
    S_RUN,
    S_STALL
  } hz_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load in EX and
// the instruction in ID. Ports: EX load info, ID sources, o_hazard.
module load_use_detect
  import mips_pkg::*;
(
  input  logic       i_ex_valid,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rt,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_alu_src,
  input  logic       i_id_mem_write,
  output logic       o_hazard
);

  logic rt_used;
  logic rs_hit;
  logic rt_hit;

  // RT is a true source for R-type ops and as store data.
  assign rt_used = ~i_id_alu_src | i_id_mem_write;
  assign rs_hit  = (i_ex_rt == i_id_rs);
  assign rt_hit  = (i_ex_rt == i_id_rt) & rt_used;

  assign o_hazard = i_ex_valid & i_ex_mem_read
                  & (i_ex_rt != REG_ZERO) & i_id_valid
                  & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble, $zero forcing and a
// saturating stall counter. Ports: ID fields in, EX bundle out,
// o_stall to IF/ID. Optional WB bypass: macro ID_EX_WB_BYPASS_EN.
module id_ex_stage #(
  parameter int CTRL_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_id_valid,
  input  logic [4:0]        i_RS,
  input  logic [4:0]        i_RT,
  input  logic [4:0]        i_RD,
  input  logic [31:0]       i_src1,
  input  logic [31:0]       i_src2,
  input  logic [15:0]       i_imm16,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic              i_wb_en,
  input  logic [4:0]        i_wb_addr,
  input  logic [31:0]       i_wb_data,
  input  logic              i_ex_hold,
  input  logic              i_flush,
  output logic              o_stall,
  output logic              o_ex_valid,
  output logic [31:0]       o_ex_src1,
  output logic [31:0]       o_ex_src2,
  output logic [31:0]       o_ex_imm32,
  output logic [4:0]        o_ex_RS,
  output logic [4:0]        o_ex_RT,
  output logic [4:0]        o_ex_dest,
  output logic [CTRL_W-1:0] o_ex_ctrl,
  output logic [CNT_W-1:0]  o_stall_cnt
);

  import mips_pkg::*;

  id_ex_t     ex_q, ex_d, ld;
  ctrl_t      id_ctrl;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  hz_state_e  state_q, state_d;
  logic       hazard;
  logic       hz_bubble;

  assign id_ctrl = i_ctrl;

  load_use_detect u_lud (
    .i_ex_valid    (ex_q.valid),
    .i_ex_mem_read (ex_q.ctrl.mem_read),
    .i_ex_rt       (ex_q.rt),
    .i_id_valid    (i_id_valid),
    .i_id_rs       (i_RS),
    .i_id_rt       (i_RT),
    .i_id_alu_src  (id_ctrl.alu_src),
    .i_id_mem_write(id_ctrl.mem_write),
    .o_hazard      (hazard)
  );

  assign o_stall = (hazard & ~i_flush) | i_ex_hold;

`ifndef ID_EX_WB_BYPASS_EN
  logic unused_wb;
  assign unused_wb = ^{i_wb_en, i_wb_addr, i_wb_data};
`endif

  always_comb begin
    ld       = '0;
    ld.valid = i_id_valid;
    ld.ctrl  = i_id_valid ? id_ctrl : '0;
    ld.src1  = i_src1;
    ld.src2  = i_src2;
`ifdef ID_EX_WB_BYPASS_EN
    // Same-cycle RF write is not yet visible on the read port.
    if (i_wb_en && i_wb_addr != REG_ZERO) begin
      if (i_wb_addr == i_RS) ld.src1 = i_wb_data;
      if (i_wb_addr == i_RT) ld.src2 = i_wb_data;
    end
`endif
    if (i_RS == REG_ZERO) ld.src1 = '0;
    if (i_RT == REG_ZERO) ld.src2 = '0;
    ld.imm32 = {{16{i_imm16[15]}}, i_imm16};
    ld.rs    = i_RS;
    ld.rt    = i_RT;
    if (ld.ctrl.reg_write)
      ld.dest = ld.ctrl.reg_dst ? i_RD : i_RT;
    else
      ld.dest = REG_ZERO;
  end

  always_comb begin
    ex_d      = ex_q;
    cnt_d     = cnt_q;
    hz_bubble = 1'b0;
    if (i_flush) begin
      ex_d = '0;
    end else if (i_ex_hold) begin
      ex_d = ex_q;
    end else if (hazard) begin
      ex_d      = '0;
      hz_bubble = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ex_d = ld;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:   if (hz_bubble) state_d = S_STALL;
      S_STALL: state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ex_q    <= '0;
      cnt_q   <= '0;
      state_q <= S_RUN;
    end else begin
      ex_q    <= ex_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign o_ex_valid  = ex_q.valid;
  assign o_ex_src1   = ex_q.src1;
  assign o_ex_src2   = ex_q.src2;
  assign o_ex_imm32  = ex_q.imm32;
  assign o_ex_RS     = ex_q.rs;
  assign o_ex_RT     = ex_q.rt;
  assign o_ex_dest   = ex_q.dest;
  assign o_ex_ctrl   = ex_q.ctrl;
  assign o_stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus
// randomized traffic against a behavioural model of the EX register.
module tb_id_ex_stage;

  localparam int CNT_W = 10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int VW = 122 + CNT_W;
  // {reg_write,mem_read,mem_write,mem_to_reg,alu_src,reg_dst,alu_op}
  localparam logic [9:0] C_LW  = 10'b1101100000;
  localparam logic [9:0] C_ADD = 10'b1000010000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  rs, rt, rd;
  logic [31:0] src1, src2;
  logic [15:0] imm;
  logic [9:0]  ctrl;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        hold, flush;

  logic        o_stall, o_ex_valid;
  logic [31:0] o_ex_src1, o_ex_src2, o_ex_imm32;
  logic [4:0]  o_ex_RS, o_ex_RT, o_ex_dest;
  logic [9:0]  o_ex_ctrl;
  logic [CNT_W-1:0] o_stall_cnt;

  logic        m_valid;
  logic [31:0] m_src1, m_src2, m_imm;
  logic [4:0]  m_rs, m_rt, m_dest;
  logic [9:0]  m_ctrl;
  logic [CNT_W-1:0] m_cnt;

  int checks = 0;
  int errors = 0;

  wire [VW-1:0] dut_vec = {o_ex_valid, o_ex_src1, o_ex_src2,
    o_ex_imm32, o_ex_RS, o_ex_RT, o_ex_dest, o_ex_ctrl, o_stall_cnt};
  wire [VW-1:0] exp_vec = {m_valid, m_src1, m_src2,
    m_imm, m_rs, m_rt, m_dest, m_ctrl, m_cnt};

  id_ex_stage #(.CTRL_W(10), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_id_valid(id_valid),
    .i_RS(rs), .i_RT(rt), .i_RD(rd),
    .i_src1(src1), .i_src2(src2), .i_imm16(imm), .i_ctrl(ctrl),
    .i_wb_en(wb_en), .i_wb_addr(wb_addr), .i_wb_data(wb_data),
    .i_ex_hold(hold), .i_flush(flush),
    .o_stall(o_stall), .o_ex_valid(o_ex_valid),
    .o_ex_src1(o_ex_src1), .o_ex_src2(o_ex_src2),
    .o_ex_imm32(o_ex_imm32), .o_ex_RS(o_ex_RS), .o_ex_RT(o_ex_RT),
    .o_ex_dest(o_ex_dest), .o_ex_ctrl(o_ex_ctrl),
    .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  // A load sits in EX and ID reads its target register as a source.
  function automatic logic model_hazard();
    logic reads_rs, reads_rt;
    reads_rs = (m_rt == rs);
    reads_rt = (m_rt == rt) && (!ctrl[5] || ctrl[7]);
    return m_valid && m_ctrl[8] && m_rt != 0 && id_valid
           && (reads_rs || reads_rt);
  endfunction

  function automatic logic exp_stall();
    return (model_hazard() && !flush) || hold;
  endfunction

  function automatic logic [31:0] operand(input logic [4:0] idx,
                                          input logic [31:0] rf);
    if (idx == 0) return 32'd0;
`ifdef ID_EX_WB_BYPASS_EN
    if (wb_en && wb_addr == idx) return wb_data;
`endif
    return rf;
  endfunction

  task automatic model_clear();
    m_valid = 0; m_src1 = 0; m_src2 = 0; m_imm = 0;
    m_rs = 0; m_rt = 0; m_dest = 0; m_ctrl = 0;
  endtask

  task automatic step();
    logic hz;
    hz = model_hazard();
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
      m_cnt = 0;
    end else if (flush) begin
      model_clear();
    end else if (hold) begin
      m_valid = m_valid;
    end else if (hz) begin
      model_clear();
      if (m_cnt != CNT_MAX) m_cnt = m_cnt + 1'b1;
    end else begin
      m_valid = id_valid;
      m_ctrl  = id_valid ? ctrl : 10'd0;
      m_src1  = operand(rs, src1);
      m_src2  = operand(rt, src2);
      m_imm   = 32'($signed(imm));
      m_rs    = rs;
      m_rt    = rt;
      if (!m_ctrl[9]) m_dest = 0;
      else if (m_ctrl[4]) m_dest = rd;
      else m_dest = rt;
    end
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] a,
                        input logic [4:0] b, input logic [4:0] c,
                        input logic [15:0] im, input logic [9:0] ct);
    id_valid = v; rs = a; rt = b; rd = c; imm = im; ctrl = ct;
    src1 = $urandom; src2 = $urandom;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; hold = 0; flush = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    set_id(1, 5'd3, 5'd4, 5'd6, 16'h1234, C_ADD);
    step(); step();
    checks++;
    if (dut_vec !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h want 0", dut_vec);
    end
    checks++;
    if (o_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_stall got %b want 0", o_stall);
    end
    rst_n = 1;
  endtask

  task automatic test_load_use();
    set_id(1, 5'd3, 5'd5, 5'd0, 16'h0004, C_LW);
    step();
    set_id(1, 5'd5, 5'd6, 5'd7, 16'h0000, C_ADD);
    checks++;
    if (o_stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_stall got %b want 1", o_stall);
    end
    step();
    checks++;
    if ({o_ex_valid, o_ex_ctrl, o_stall_cnt} !== {1'b0, 10'd0, CNT_W'(1)}) begin
      errors++;
      $display("FAIL lu_bubble got v=%b c=%h n=%0d want v=0 c=0 n=1",
               o_ex_valid, o_ex_ctrl, o_stall_cnt);
    end
    checks++;
    if (o_stall !== 1'b0) begin
      errors++;
      $display("FAIL lu_release got %b want 0", o_stall);
    end
    step();
    checks++;
    if ({o_ex_valid, o_ex_ctrl, o_ex_RS, o_ex_dest} !==
        {1'b1, C_ADD, 5'd5, 5'd7}) begin
      errors++;
      $display("FAIL lu_add_load got v=%b c=%h rs=%0d d=%0d want 1 %h 5 7",
               o_ex_valid, o_ex_ctrl, o_ex_RS, o_ex_dest, C_ADD);
    end
  endtask

  task automatic test_zero_reg();
    set_id(1, 5'd2, 5'd0, 5'd0, 16'h0000, C_LW);
    step();
    set_id(1, 5'd0, 5'd0, 5'd4, 16'h0000, C_ADD);
    src1 = 32'hDEADBEEF;
    #1;
    checks++;
    if (o_stall !== 1'b0) begin
      errors++;
      $display("FAIL zero_stall got %b want 0", o_stall);
    end
    step();
    checks++;
    if ({o_ex_src1, o_ex_src2} !== 64'd0) begin
      errors++;
      $display("FAIL zero_operands got %h %h want 0 0", o_ex_src1, o_ex_src2);
    end
  endtask

  task automatic test_flush();
    logic [CNT_W-1:0] c0;
    set_id(1, 5'd1, 5'd5, 5'd0, 16'h0000, C_LW);
    step();
    set_id(1, 5'd5, 5'd2, 5'd3, 16'h0000, C_ADD);
    flush = 1;
    #1;
    c0 = m_cnt;
    checks++;
    if (o_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall got %b want 0", o_stall);
    end
    step();
    flush = 0;
    checks++;
    if ({o_ex_valid, o_ex_ctrl, o_ex_dest, o_stall_cnt} !==
        {1'b0, 10'd0, 5'd0, c0}) begin
      errors++;
      $display("FAIL flush_bubble got v=%b c=%h d=%0d n=%0d want 0 0 0 %0d",
               o_ex_valid, o_ex_ctrl, o_ex_dest, o_stall_cnt, c0);
    end
  endtask

  task automatic test_hold();
    logic [VW-1:0] snap;
    set_id(1, 5'd9, 5'd10, 5'd11, 16'h7FFF, C_ADD);
    step();
    snap = exp_vec;
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 5'($urandom), 5'($urandom), 5'($urandom),
             16'($urandom), 10'($urandom));
      checks++;
      if (o_stall !== 1'b1) begin
        errors++;
        $display("FAIL hold_stall[%0d] got %b want 1", i, o_stall);
      end
      step();
      checks++;
      if (dut_vec !== snap) begin
        errors++;
        $display("FAIL hold_frozen[%0d] got %h want %h", i, dut_vec, snap);
      end
    end
    hold = 0;
    set_id(1, 5'd12, 5'd13, 5'd14, 16'h0042, C_ADD);
    step();
    checks++;
    if (dut_vec !== exp_vec || o_ex_RS !== 5'd12) begin
      errors++;
      $display("FAIL hold_release got %h want %h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_imm_bypass();
    logic [31:0] want;
    set_id(1, 5'd1, 5'd2, 5'd3, 16'h8001, C_ADD);
    step();
    checks++;
    if (o_ex_imm32 !== 32'hFFFF8001) begin
      errors++;
      $display("FAIL imm_sext got %h want FFFF8001", o_ex_imm32);
    end
    set_id(1, 5'd1, 5'd7, 5'd3, 16'h0000, C_ADD);
    wb_en = 1; wb_addr = 5'd7; wb_data = 32'h1234;
    src2 = 32'hCAFE0000;
`ifdef ID_EX_WB_BYPASS_EN
    want = 32'h1234;
`else
    want = 32'hCAFE0000;
`endif
    step();
    wb_en = 0;
    checks++;
    if (o_ex_src2 !== want) begin
      errors++;
      $display("FAIL wb_bypass got %h want %h", o_ex_src2, want);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      id_valid = ($urandom_range(0, 7) != 0);
      rs = 5'($urandom_range(0, 3));
      rt = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      src1 = $urandom; src2 = $urandom; imm = 16'($urandom);
      ctrl = ($urandom_range(0, 1) == 1) ? (C_LW | 10'($urandom_range(0, 15)))
                                         : 10'($urandom);
      wb_en = 1'($urandom); wb_addr = 5'($urandom_range(0, 3));
      wb_data = $urandom;
      flush = ($urandom_range(0, 9) == 0);
      hold  = ($urandom_range(0, 7) == 0);
      #1;
      checks++;
      if (o_stall !== exp_stall()) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand_stall[%0d] got %b want %b", i, o_stall, exp_stall());
      end
      step();
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        if (bad++ < 10)
          $display("FAIL rand_regs[%0d] got %h want %h", i, dut_vec, exp_vec);
      end
    end
    flush = 0; hold = 0; wb_en = 0;
  endtask

  task automatic test_saturate_reset();
    set_id(1, 5'd5, 5'd5, 5'd0, 16'h0000, C_LW);
    for (int i = 0; i < 2 * (int'(CNT_MAX) + 8); i++) step();
    checks++;
    if (o_stall_cnt !== CNT_MAX || m_cnt !== CNT_MAX) begin
      errors++;
      $display("FAIL stall_saturate got %h want %h", o_stall_cnt, CNT_MAX);
    end
    if (!model_hazard()) step();
    checks++;
    if (o_stall !== 1'b1) begin
      errors++;
      $display("FAIL sat_stall got %b want 1", o_stall);
    end
    rst_n = 0;
    step();
    rst_n = 1;
    checks++;
    if (dut_vec !== '0) begin
      errors++;
      $display("FAIL reset_mid_stall got %h want 0", dut_vec);
    end
  endtask

  initial begin
    m_cnt = 0;
    model_clear();
    test_reset();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_hold();
    test_imm_bypass();
    test_random();
    test_saturate_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
